// File: rtl/adma_atx_exec.sv
// rtl/adma_atx_exec.sv - in-order outstanding table issuing AXI AR/AW and retiring on B
// Optional macro ADMA_ATX_EXEC_AW_AFTER_AR_EN holds each AW until its AR has handshaken.
module adma_atx_exec #(
  parameter int DMA_CHN_NUM   = 4,
  parameter int SRC_ADDR_W    = 32,
  parameter int DST_ADDR_W    = 32,
  parameter int MST_ID_W      = 5,
  parameter int ATX_LEN_W     = 8,
  parameter int OUTSTD_NUM    = 4,
  parameter int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
  input  logic [MST_ID_W-1:0]      arid,
  input  logic [SRC_ADDR_W-1:0]    araddr,
  input  logic [ATX_LEN_W-1:0]     arlen,
  input  logic [1:0]               arburst,
  input  logic [MST_ID_W-1:0]      awid,
  input  logic [DST_ADDR_W-1:0]    awaddr,
  input  logic [ATX_LEN_W-1:0]     awlen,
  input  logic [1:0]               awburst,
  input  logic                     atx_vld,
  output logic                     atx_rdy,
  output logic                     atx_done,
  output logic [DMA_CHN_NUM_W-1:0] atx_done_chn_id,
  output logic                     atx_err,
  output logic [MST_ID_W-1:0]      m_arid,
  output logic [SRC_ADDR_W-1:0]    m_araddr,
  output logic [ATX_LEN_W-1:0]     m_arlen,
  output logic [1:0]               m_arburst,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  output logic [MST_ID_W-1:0]      m_awid,
  output logic [DST_ADDR_W-1:0]    m_awaddr,
  output logic [ATX_LEN_W-1:0]     m_awlen,
  output logic [1:0]               m_awburst,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  input  logic [MST_ID_W-1:0]      m_bid,
  input  logic [1:0]               m_bresp,
  input  logic                     m_bvalid,
  output logic                     m_bready
);

  localparam int IDX_W = $clog2(OUTSTD_NUM);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(OUTSTD_NUM);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] ar_ptr_q, ar_ptr_d;
  logic [PTR_W-1:0] aw_ptr_q, aw_ptr_d;
  logic [PTR_W-1:0] rt_ptr_q, rt_ptr_d;
  logic             atx_done_q, atx_done_d;
  logic             atx_err_q, atx_err_d;
  logic [DMA_CHN_NUM_W-1:0] atx_done_chn_id_q, atx_done_chn_id_d;

  logic [DMA_CHN_NUM_W-1:0] chn_tbl_q     [OUTSTD_NUM];
  logic [MST_ID_W-1:0]      arid_tbl_q    [OUTSTD_NUM];
  logic [SRC_ADDR_W-1:0]    araddr_tbl_q  [OUTSTD_NUM];
  logic [ATX_LEN_W-1:0]     arlen_tbl_q   [OUTSTD_NUM];
  logic [1:0]               arburst_tbl_q [OUTSTD_NUM];
  logic [MST_ID_W-1:0]      awid_tbl_q    [OUTSTD_NUM];
  logic [DST_ADDR_W-1:0]    awaddr_tbl_q  [OUTSTD_NUM];
  logic [ATX_LEN_W-1:0]     awlen_tbl_q   [OUTSTD_NUM];
  logic [1:0]               awburst_tbl_q [OUTSTD_NUM];

  logic [PTR_W-1:0] occ, ar_pend, aw_pend, b_pend;
  logic [IDX_W-1:0] wr_idx, ar_idx, aw_idx, rt_idx;
  logic             acc, ar_hs, aw_hs, b_hs;
  logic             unused_bresp0;

  assign unused_bresp0 = m_bresp[0];

  assign occ     = wr_ptr_q - rt_ptr_q;
  assign ar_pend = wr_ptr_q - ar_ptr_q;
  assign aw_pend = wr_ptr_q - aw_ptr_q;
  assign b_pend  = aw_ptr_q - rt_ptr_q;

  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign ar_idx = ar_ptr_q[IDX_W-1:0];
  assign aw_idx = aw_ptr_q[IDX_W-1:0];
  assign rt_idx = rt_ptr_q[IDX_W-1:0];

  // Ready looks at pre-retire occupancy, so a full table never accepts and retires together.
  assign atx_rdy   = (occ != FULL_CNT);
  assign m_arvalid = (ar_pend != '0);
`ifdef ADMA_ATX_EXEC_AW_AFTER_AR_EN
  assign m_awvalid = (aw_pend != '0) && (ar_ptr_q != aw_ptr_q);
`else
  assign m_awvalid = (aw_pend != '0);
`endif
  assign m_bready  = (b_pend != '0);

  assign acc   = atx_vld && atx_rdy;
  assign ar_hs = m_arvalid && m_arready;
  assign aw_hs = m_awvalid && m_awready;
  assign b_hs  = m_bvalid && m_bready;

  assign m_arid    = arid_tbl_q[ar_idx];
  assign m_araddr  = araddr_tbl_q[ar_idx];
  assign m_arlen   = arlen_tbl_q[ar_idx];
  assign m_arburst = arburst_tbl_q[ar_idx];
  assign m_awid    = awid_tbl_q[aw_idx];
  assign m_awaddr  = awaddr_tbl_q[aw_idx];
  assign m_awlen   = awlen_tbl_q[aw_idx];
  assign m_awburst = awburst_tbl_q[aw_idx];

  assign atx_done        = atx_done_q;
  assign atx_done_chn_id = atx_done_chn_id_q;
  assign atx_err         = atx_err_q;

  always_comb begin
    wr_ptr_d          = wr_ptr_q + PTR_W'(acc);
    ar_ptr_d          = ar_ptr_q + PTR_W'(ar_hs);
    aw_ptr_d          = aw_ptr_q + PTR_W'(aw_hs);
    rt_ptr_d          = rt_ptr_q + PTR_W'(b_hs);
    atx_done_d        = b_hs;
    atx_done_chn_id_d = atx_done_chn_id_q;
    atx_err_d         = 1'b0;
    if (b_hs) begin
      atx_done_chn_id_d = chn_tbl_q[rt_idx];
      atx_err_d         = m_bresp[1] | (m_bid != awid_tbl_q[rt_idx]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q          <= '0;
      ar_ptr_q          <= '0;
      aw_ptr_q          <= '0;
      rt_ptr_q          <= '0;
      atx_done_q        <= 1'b0;
      atx_done_chn_id_q <= '0;
      atx_err_q         <= 1'b0;
    end else begin
      wr_ptr_q          <= wr_ptr_d;
      ar_ptr_q          <= ar_ptr_d;
      aw_ptr_q          <= aw_ptr_d;
      rt_ptr_q          <= rt_ptr_d;
      atx_done_q        <= atx_done_d;
      atx_done_chn_id_q <= atx_done_chn_id_d;
      atx_err_q         <= atx_err_d;
    end
  end

  // Table payload needs no reset: pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (acc) begin
      chn_tbl_q[wr_idx]     <= atx_chn_id;
      arid_tbl_q[wr_idx]    <= arid;
      araddr_tbl_q[wr_idx]  <= araddr;
      arlen_tbl_q[wr_idx]   <= arlen;
      arburst_tbl_q[wr_idx] <= arburst;
      awid_tbl_q[wr_idx]    <= awid;
      awaddr_tbl_q[wr_idx]  <= awaddr;
      awlen_tbl_q[wr_idx]   <= awlen;
      awburst_tbl_q[wr_idx] <= awburst;
    end
  end

endmodule

// File: tb/tb_adma_atx_exec.sv
// tb/tb_adma_atx_exec.sv - randomized and directed bench for adma_atx_exec against a queue model
module tb_adma_atx_exec;
    localparam int OUTSTD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  atx_chn_id;
    logic [4:0]  arid, awid;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen, awlen;
    logic [1:0]  arburst, awburst;
    logic        atx_vld, atx_rdy, atx_done, atx_err;
    logic [1:0]  atx_done_chn_id;
    logic [4:0]  m_arid, m_awid, m_bid;
    logic [31:0] m_araddr, m_awaddr;
    logic [7:0]  m_arlen, m_awlen;
    logic [1:0]  m_arburst, m_awburst, m_bresp;
    logic        m_arvalid, m_arready, m_awvalid, m_awready, m_bvalid, m_bready;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  chn;
        logic [4:0]  arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [1:0]  arburst;
        logic [4:0]  awid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [1:0]  awburst;
        bit          ar_done;
        bit          aw_done;
    } ent_t;

    ent_t       tbl[$];
    bit         exp_done = 0;
    logic [1:0] exp_chn = '0;
    logic       exp_err = 0;

    adma_atx_exec dut (
        .clk(clk), .rst_n(rst_n), .atx_chn_id(atx_chn_id),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .atx_vld(atx_vld), .atx_rdy(atx_rdy), .atx_done(atx_done),
        .atx_done_chn_id(atx_done_chn_id), .atx_err(atx_err),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic int first_ar();
        for (int i = 0; i < tbl.size(); i++) if (!tbl[i].ar_done) return i;
        return -1;
    endfunction

    function automatic int first_aw();
        for (int i = 0; i < tbl.size(); i++) if (!tbl[i].aw_done) return i;
        return -1;
    endfunction

    task automatic rand_offer();
        atx_chn_id = 2'($urandom);
        arid = 5'($urandom);  araddr = $urandom; arlen = 8'($urandom); arburst = 2'($urandom);
        awid = 5'($urandom);  awaddr = $urandom; awlen = 8'($urandom); awburst = 2'($urandom);
    endtask

    task automatic drive_b(input bit en, input logic [1:0] resp, input bit bad_id);
        if (en && tbl.size() > 0 && tbl[0].ar_done && tbl[0].aw_done) begin
            m_bvalid = 1'b1;
            m_bid    = tbl[0].awid ^ (bad_id ? 5'h1 : 5'h0);
            m_bresp  = resp;
        end else begin
            m_bvalid = 1'b0;
            m_bid    = 5'($urandom);
            m_bresp  = 2'($urandom);
        end
    endtask

    task automatic cycle();
        int   ai, wi;
        bit   e_rdy, e_arv, e_awv, e_br, acc, arh, awh, bh;
        ent_t e;
        ai    = first_ar();
        wi    = first_aw();
        e_rdy = (tbl.size() != OUTSTD);
        e_arv = (ai >= 0);
        e_awv = (wi >= 0);
`ifdef ADMA_ATX_EXEC_AW_AFTER_AR_EN
        if (wi >= 0) e_awv = tbl[wi].ar_done;
`endif
        e_br  = (tbl.size() > 0) && tbl[0].aw_done;
        checks++;
        if (atx_rdy !== e_rdy) begin
            failures++;
            $error("FAIL atx_rdy observed=%0h expected=%0h", atx_rdy, e_rdy);
        end
        checks++;
        if (m_arvalid !== e_arv) begin
            failures++;
            $error("FAIL m_arvalid observed=%0h expected=%0h", m_arvalid, e_arv);
        end
        checks++;
        if (m_awvalid !== e_awv) begin
            failures++;
            $error("FAIL m_awvalid observed=%0h expected=%0h", m_awvalid, e_awv);
        end
        checks++;
        if (m_bready !== e_br) begin
            failures++;
            $error("FAIL m_bready observed=%0h expected=%0h", m_bready, e_br);
        end
        checks++;
        if (atx_done !== exp_done) begin
            failures++;
            $error("FAIL atx_done observed=%0h expected=%0h", atx_done, exp_done);
        end
        if (e_arv) begin
            checks++;
            if ({m_arid, m_araddr, m_arlen, m_arburst} !==
                {tbl[ai].arid, tbl[ai].araddr, tbl[ai].arlen, tbl[ai].arburst}) begin
                failures++;
                $error("FAIL ar_fields observed=%0h expected=%0h",
                       {m_arid, m_araddr, m_arlen, m_arburst},
                       {tbl[ai].arid, tbl[ai].araddr, tbl[ai].arlen, tbl[ai].arburst});
            end
        end
        if (e_awv) begin
            checks++;
            if ({m_awid, m_awaddr, m_awlen, m_awburst} !==
                {tbl[wi].awid, tbl[wi].awaddr, tbl[wi].awlen, tbl[wi].awburst}) begin
                failures++;
                $error("FAIL aw_fields observed=%0h expected=%0h",
                       {m_awid, m_awaddr, m_awlen, m_awburst},
                       {tbl[wi].awid, tbl[wi].awaddr, tbl[wi].awlen, tbl[wi].awburst});
            end
        end
        if (exp_done) begin
            checks++;
            if (atx_done_chn_id !== exp_chn) begin
                failures++;
                $error("FAIL atx_done_chn_id observed=%0h expected=%0h", atx_done_chn_id, exp_chn);
            end
            checks++;
            if (atx_err !== exp_err) begin
                failures++;
                $error("FAIL atx_err observed=%0h expected=%0h", atx_err, exp_err);
            end
        end
        acc = atx_vld && e_rdy;
        arh = e_arv && m_arready;
        awh = e_awv && m_awready;
        bh  = m_bvalid && e_br;
        e = '{atx_chn_id, arid, araddr, arlen, arburst, awid, awaddr, awlen, awburst, 1'b0, 1'b0};
        @(posedge clk);
        #1;
        if (arh) tbl[ai].ar_done = 1'b1;
        if (awh) tbl[wi].aw_done = 1'b1;
        exp_done = bh;
        if (bh) begin
            exp_chn = tbl[0].chn;
            exp_err = m_bresp[1] | (m_bid != tbl[0].awid);
            void'(tbl.pop_front());
        end
        if (acc) tbl.push_back(e);
    endtask

    task automatic drain(input int err_idx);
        int n = 0;
        atx_vld = 1'b0; m_arready = 1'b1; m_awready = 1'b1;
        for (int i = 0; i < 60 && tbl.size() > 0; i++) begin
            drive_b(1'b1, (n == err_idx) ? 2'b10 : 2'b00, 1'b0);
            if (m_bvalid) n++;
            cycle();
        end
        m_bvalid = 1'b0;
        cycle();
        checks++;
        if (tbl.size() !== 0) begin
            failures++;
            $error("FAIL drain_bound observed=%0d expected=0", tbl.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; atx_vld = 1'b0; m_arready = 1'b0; m_awready = 1'b0;
        m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
        rand_offer();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (atx_rdy !== 1'b1) begin
            failures++;
            $error("FAIL rst_atx_rdy observed=%0h expected=1", atx_rdy);
        end
        checks++;
        if (m_arvalid !== 1'b0) begin
            failures++;
            $error("FAIL rst_m_arvalid observed=%0h expected=0", m_arvalid);
        end
        checks++;
        if (m_awvalid !== 1'b0) begin
            failures++;
            $error("FAIL rst_m_awvalid observed=%0h expected=0", m_awvalid);
        end
        checks++;
        if (m_bready !== 1'b0) begin
            failures++;
            $error("FAIL rst_m_bready observed=%0h expected=0", m_bready);
        end
        checks++;
        if (atx_done !== 1'b0) begin
            failures++;
            $error("FAIL rst_atx_done observed=%0h expected=0", atx_done);
        end
        checks++;
        if (atx_err !== 1'b0) begin
            failures++;
            $error("FAIL rst_atx_err observed=%0h expected=0", atx_err);
        end
        checks++;
        if (atx_done_chn_id !== 2'd0) begin
            failures++;
            $error("FAIL rst_done_chn observed=%0h expected=0", atx_done_chn_id);
        end
        rst_n = 1'b1;
        cycle();

        atx_chn_id = 2'd2; araddr = 32'h1000; awaddr = 32'h2000; arlen = 8'd7;
        arid = 5'd3; awid = 5'd9; awlen = 8'd7; arburst = 2'b01; awburst = 2'b01;
        m_arready = 1'b1; m_awready = 1'b1; atx_vld = 1'b1;
        cycle();
        atx_vld = 1'b0;
        repeat (4) cycle();
        drain(-1);

        m_bvalid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_offer(); atx_vld = 1'b1; cycle();
        end
        atx_vld = 1'b0;
        drive_b(1'b1, 2'b00, 1'b0);
        cycle();
        m_bvalid = 1'b0;
        cycle();
        for (int i = 0; i < 10; i++) begin
            rand_offer(); atx_vld = 1'b1;
            drive_b(1'b1, 2'b00, 1'b0);
            cycle();
        end
        drain(-1);

        m_arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_offer(); atx_vld = 1'b1; cycle();
        end
        atx_vld = 1'b0;
        repeat (3) cycle();
        drain(-1);

        for (int i = 0; i < 3; i++) begin
            rand_offer(); atx_vld = 1'b1; cycle();
        end
        drain(1);

        m_arready = 1'b0; m_awready = 1'b1;
        rand_offer(); atx_vld = 1'b1; cycle();
        atx_vld = 1'b0;
        repeat (3) cycle();
        m_arready = 1'b1;
        repeat (2) cycle();
        drain(-1);

        m_bvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_offer(); atx_vld = 1'b1; m_arready = 1'b0; cycle();
        end
        atx_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_arvalid !== 1'b0) begin
            failures++;
            $error("FAIL midrst_m_arvalid observed=%0h expected=0", m_arvalid);
        end
        checks++;
        if (m_awvalid !== 1'b0) begin
            failures++;
            $error("FAIL midrst_m_awvalid observed=%0h expected=0", m_awvalid);
        end
        checks++;
        if (m_bready !== 1'b0) begin
            failures++;
            $error("FAIL midrst_m_bready observed=%0h expected=0", m_bready);
        end
        tbl.delete();
        exp_done = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (atx_done !== 1'b0) begin
            failures++;
            $error("FAIL midrst_atx_done observed=%0h expected=0", atx_done);
        end
        rst_n = 1'b1;
        repeat (2) cycle();
        rand_offer(); atx_vld = 1'b1; cycle();
        drain(-1);

        for (int i = 0; i < 400; i++) begin
            rand_offer();
            atx_vld   = ($urandom_range(0, 99) < 60);
            m_arready = ($urandom_range(0, 99) < 70);
            m_awready = ($urandom_range(0, 99) < 70);
            drive_b($urandom_range(0, 99) < 50, 2'($urandom), $urandom_range(0, 99) < 10);
            cycle();
        end
        drain(-1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
